// File: rtl/bin2bcd_hexdisp.sv
// Sequential double-dabble binary to 8-digit BCD converter
// with active-low seven-segment drivers for HEX0..HEX7.
module bin2bcd_hexdisp #(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] bin_in,
   output logic        out_valid,
   output logic [31:0] bcd_out,
   output logic        overflow,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7
);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] work_q, work_d;
   logic        sticky_q, sticky_d;
   logic [31:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;
   logic        ov_q, ov_d;
   logic [31:0] adj;
   logic [6:0]  seg [8];

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      adj = work_q;
      for (int i = 0; i < 8; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      work_d   = work_q;
      sticky_d = sticky_q;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
      ov_d     = 1'b0;
      in_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift_d  = bin_in;
               work_d   = '0;
               sticky_d = 1'b0;
               cnt_d    = '0;
               state_d  = CONV;
            end
         end
         CONV: begin
            // bit leaving digit 7 is a multiple of 10^8 and is dropped
            {work_d, shift_d} = {adj[30:0], shift_q, 1'b0};
            sticky_d = sticky_q | adj[31];
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = LOAD;
         end
         LOAD: begin
            bcd_d   = work_q;
            ovf_d   = sticky_q;
            ov_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         work_q   <= '0;
         sticky_q <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         work_q   <= work_d;
         sticky_q <= sticky_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
         ov_q     <= ov_d;
      end
   end

   always_comb begin
      logic       any;
      logic [3:0] dig;
      logic       show;
      any = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         dig    = bcd_q[4*k +: 4];
         any    = any | (dig != 4'd0);
         show   = any || (k == 0) || !BLANK_LZ;
         seg[k] = show ? seg7(dig) : 7'b1111111;
      end
   end

   assign out_valid = ov_q;
   assign bcd_out   = bcd_q;
   assign overflow  = ovf_q;
   assign hex0      = seg[0];
   assign hex1      = seg[1];
   assign hex2      = seg[2];
   assign hex3      = seg[3];
   assign hex4      = seg[4];
   assign hex5      = seg[5];
   assign hex6      = seg[6];
   assign hex7      = seg[7];

endmodule

// File: tb/tb_bin2bcd_hexdisp.sv
// Directed bench for bin2bcd_hexdisp: one blanking and one
// non-blanking instance share stimulus.
module tb_bin2bcd_hexdisp;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] bin_in;
   logic        in_ready, out_valid, overflow;
   logic [31:0] bcd_out;
   logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;
   logic        rdy_b, ov_b, ovf_b;
   logic [31:0] bcd_b;
   logic [6:0]  g0, g1, g2, g3, g4, g5, g6, g7;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] Z  = 7'b1000000;

   always #5 clk = ~clk;

   bin2bcd_hexdisp u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_ready(in_ready), .bin_in(bin_in),
      .out_valid(out_valid), .bcd_out(bcd_out),
      .overflow(overflow),
      .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3),
      .hex4(h4), .hex5(h5), .hex6(h6), .hex7(h7)
   );

   bin2bcd_hexdisp #(.BLANK_LZ(1'b0)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_ready(rdy_b), .bin_in(bin_in),
      .out_valid(ov_b), .bcd_out(bcd_b),
      .overflow(ovf_b),
      .hex0(g0), .hex1(g1), .hex2(g2), .hex3(g3),
      .hex4(g4), .hex5(g5), .hex6(g6), .hex7(g7)
   );

   wire [55:0] ha = {h7, h6, h5, h4, h3, h2, h1, h0};
   wire [55:0] hb = {g7, g6, g5, g4, g3, g2, g1, g0};

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic accept(input logic [31:0] v);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         step();
         w++;
      end
      chk("accept_ready", in_ready, 1);
      in_valid = 1'b1;
      bin_in   = v;
      step();
      in_valid = 1'b0;
      bin_in   = 32'hDEAD_BEEF;
   endtask

   task automatic wait_ov(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic conv(input string tag, input logic [31:0] v,
                       input logic [31:0] eb, input logic eo);
      int n;
      accept(v);
      wait_ov(n);
      chk({tag, "_lat"}, n, 33);
      chk({tag, "_bcd"}, bcd_out, eb);
      chk({tag, "_ovf"}, overflow, eo);
   endtask

   initial begin
      int n, busy, hits, t1, t2, t3;
      rst      = 1'b1;
      in_valid = 1'b0;
      bin_in   = '0;
      step();
      step();
      rst = 1'b0;
      chk("rst_ready", in_ready, 1);
      chk("rst_ov", out_valid, 0);
      chk("rst_bcd", bcd_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_hexa", ha, {BL, BL, BL, BL, BL, BL, BL, Z});
      chk("rst_hexb", hb, {8{Z}});

      // 123456: latency, busy window, digits
      accept(32'd123456);
      n = 0;
      busy = 0;
      while (!out_valid && n < 40) begin
         if (!in_ready) busy++;
         step();
         n++;
      end
      chk("t1_lat", n, 33);
      chk("t1_busy", busy, 33);
      chk("t1_ready_back", in_ready, 1);
      chk("t1_bcd", bcd_out, 32'h0012_3456);
      chk("t1_ovf", overflow, 0);
      chk("t1_hex0", h0, 7'b0000010);
      chk("t1_hex5", h5, 7'b1111001);
      chk("t1_hex76", {h7, h6}, {BL, BL});
      chk("t1_hexb7", g7, Z);
      step();
      chk("t1_pulse", out_valid, 0);
      chk("t1_hold", bcd_out, 32'h0012_3456);

      conv("zero", 32'd0, 32'h0, 1'b0);
      chk("zero_hexa", ha, {BL, BL, BL, BL, BL, BL, BL, Z});
      chk("zero_hexb", hb, {8{Z}});

      conv("max8", 32'd99_999_999, 32'h9999_9999, 1'b0);
      chk("max8_hex7", h7, 7'b0010000);
      conv("ffff", 32'hFFFF_FFFF, 32'h9496_7295, 1'b1);
      chk("ffff_hex", {h7, h0}, {7'b0010000, 7'b0010010});
      conv("e8", 32'd100_000_000, 32'h0, 1'b1);
      chk("e8_hexa", ha, {BL, BL, BL, BL, BL, BL, BL, Z});

      // request held during conversion is ignored then taken later
      accept(32'd42);
      in_valid = 1'b1;
      bin_in   = 32'd777;
      wait_ov(n);
      chk("hold_lat", n, 33);
      chk("hold_bcd", bcd_out, 32'h42);
      step();
      chk("hold_acc", in_ready, 0);
      in_valid = 1'b0;
      bin_in   = 32'd0;
      wait_ov(n);
      chk("hold2_lat", n, 33);
      chk("hold2_bcd", bcd_out, 32'h777);

      // reset mid-conversion aborts
      accept(32'd5555);
      repeat (16) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ready", in_ready, 1);
      chk("abort_bcd", bcd_out, 0);
      chk("abort_ovf", overflow, 0);
      chk("abort_hex0", h0, Z);
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) hits++;
         step();
      end
      chk("abort_no_ov", hits, 0);

      // reset wins over a simultaneous request
      rst      = 1'b1;
      in_valid = 1'b1;
      bin_in   = 32'd9;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst_drop", in_ready, 1);
      step();
      chk("rst_drop2", in_ready, 1);

      conv("eight", 32'd8, 32'h8, 1'b0);

      // back-to-back with in_valid held high
      step();
      in_valid = 1'b1;
      bin_in   = 32'd1;
      step();
      bin_in = 32'd2;
      wait_ov(n);
      t1 = cyc;
      chk("b2b1", bcd_out, 32'h1);
      step();
      bin_in = 32'd3;
      wait_ov(n);
      t2 = cyc;
      chk("b2b2", bcd_out, 32'h2);
      step();
      in_valid = 1'b0;
      wait_ov(n);
      t3 = cyc;
      chk("b2b3", bcd_out, 32'h3);
      chk("b2b_gap1", t2 - t1, 34);
      chk("b2b_gap2", t3 - t2, 34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
